// File: rtl/reg_bank_w16_rd_pkg.sv
// Shared definitions for the 16-bit register bank with buffered readback.
//   DEF_WIDTH / DEF_ADDR_W : default data and address widths
//   DEF_ERR_DATA           : data returned for an unmapped read
//   rsp_t                  : read response payload {data, addr, err}
package reg_bank_w16_rd_pkg;

    localparam int unsigned DEF_WIDTH  = 16;
    localparam int unsigned DEF_ADDR_W = 3;

    localparam logic [DEF_WIDTH-1:0] DEF_ERR_DATA = 16'hDEAD;

    typedef struct packed {
        logic [DEF_WIDTH-1:0]  data;
        logic [DEF_ADDR_W-1:0] addr;
        logic                  err;
    } rsp_t;

endpackage

// File: rtl/reg_bank_w16_rd_rsp_fifo2.sv
// Two-entry synchronous FIFO for read responses. Entry 0 is always the head,
// so the head outputs come straight from a register.
//   clk, rst     : clock, synchronous active-high reset
//   i_push       : write i_push_data (ignored when full)
//   i_push_data  : response to enqueue
//   i_pop        : remove head (ignored when empty)
//   o_head       : head entry (holds last value when empty)
//   o_valid      : FIFO not empty
//   o_ready      : FIFO not full
//   o_count      : occupancy 0..2
module reg_bank_w16_rd_rsp_fifo2
    import reg_bank_w16_rd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  rsp_t       i_push_data,
    input  logic       i_pop,
    output rsp_t       o_head,
    output logic       o_valid,
    output logic       o_ready,
    output logic [1:0] o_count
);

    rsp_t       r_mem0;
    rsp_t       r_mem1;
    logic [1:0] r_count;
    logic       r_valid;
    logic       r_ready;

    logic       w_push;
    logic       w_pop;
    rsp_t       w_mem0_nxt;
    rsp_t       w_mem1_nxt;
    logic [1:0] w_count_nxt;

    assign w_push = i_push & (r_count != 2'd2);
    assign w_pop  = i_pop  & (r_count != 2'd0);

    // Next occupancy and entry contents; a pop shifts entry 1 into the head.
    always_comb begin
        w_mem0_nxt  = r_mem0;
        w_mem1_nxt  = r_mem1;
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10: begin
                w_count_nxt = r_count + 2'd1;
                if (r_count == 2'd0) begin
                    w_mem0_nxt = i_push_data;
                end else begin
                    w_mem1_nxt = i_push_data;
                end
            end
            2'b01: begin
                w_count_nxt = r_count - 2'd1;
                if (r_count == 2'd2) begin
                    w_mem0_nxt = r_mem1;
                end
            end
            2'b11: begin
                if (r_count == 2'd1) begin
                    w_mem0_nxt = i_push_data;
                end else begin
                    w_mem0_nxt = r_mem1;
                    w_mem1_nxt = i_push_data;
                end
            end
            default: begin
            end
        endcase
    end

    // State register; flags are registered from the next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem0  <= '0;
            r_mem1  <= '0;
            r_count <= 2'd0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_mem0  <= w_mem0_nxt;
            r_mem1  <= w_mem1_nxt;
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != 2'd0);
            r_ready <= (w_count_nxt != 2'd2);
        end
    end

    assign o_head  = r_mem0;
    assign o_valid = r_valid;
    assign o_ready = r_ready;
    assign o_count = r_count;

endmodule

// File: rtl/reg_bank_w16_rd.sv
// Register bank of NUM_REGS entries with a simple write port and a
// valid/ready read port whose responses pass through a 2-entry buffer.
//   clk, rst                      : clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data       : write port (unmapped addresses ignored)
//   rd_req_valid/ready, rd_req_addr : read request handshake
//   rd_rsp_valid/ready            : read response handshake
//   rd_rsp_data/addr/err          : response payload (err = unmapped address)
module reg_bank_w16_rd
    import reg_bank_w16_rd_pkg::*;
#(
    parameter int unsigned        WIDTH    = DEF_WIDTH,
    parameter int unsigned        ADDR_W   = DEF_ADDR_W,
    parameter int unsigned        NUM_REGS = 6,
    parameter logic [WIDTH-1:0]   ERR_DATA = DEF_ERR_DATA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_rsp_valid,
    input  logic              rd_rsp_ready,
    output logic [WIDTH-1:0]  rd_rsp_data,
    output logic [ADDR_W-1:0] rd_rsp_addr,
    output logic              rd_rsp_err
);

    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    logic [WIDTH-1:0] r_regs [NUM_REGS];

    logic             w_wr_mapped;
    logic             w_rd_mapped;
    logic             w_fire;
    logic             w_pop;
    logic             w_fifo_ready;
    logic             w_fifo_valid;
    logic [1:0]       w_fifo_count;
    rsp_t             w_rsp;
    rsp_t             w_head;

    assign w_wr_mapped = ({1'b0, wr_addr}     < NUM_REGS_W);
    assign w_rd_mapped = ({1'b0, rd_req_addr} < NUM_REGS_W);

    assign w_fire = rd_req_valid & w_fifo_ready;
    assign w_pop  = w_fifo_valid & rd_rsp_ready;

    // Response payload; a same-edge write to the read address wins.
    always_comb begin
        w_rsp      = '0;
        w_rsp.addr = rd_req_addr;
        if (!w_rd_mapped) begin
            w_rsp.data = ERR_DATA;
            w_rsp.err  = 1'b1;
        end else if (wr_en && (wr_addr == rd_req_addr)) begin
            w_rsp.data = wr_data;
        end else begin
            w_rsp.data = r_regs[rd_req_addr];
        end
    end

    // Register array; writes are independent of read backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en && w_wr_mapped) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    reg_bank_w16_rd_rsp_fifo2 u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_fire),
        .i_push_data (w_rsp),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (w_fifo_valid),
        .o_ready     (w_fifo_ready),
        .o_count     (w_fifo_count)
    );

    assign rd_req_ready = w_fifo_ready;
    assign rd_rsp_valid = w_fifo_valid;
    assign rd_rsp_data  = w_head.data;
    assign rd_rsp_addr  = w_head.addr;
    assign rd_rsp_err   = w_head.err;

    logic w_unused;
    assign w_unused = ^w_fifo_count;

endmodule

// File: tb/tb_reg_bank_w16_rd.sv
module tb_reg_bank_w16_rd;

    typedef struct {
        logic [15:0] d;
        logic [2:0]  a;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [2:0]  rd_req_addr;
    logic        rd_rsp_valid;
    logic        rd_rsp_ready;
    logic [15:0] rd_rsp_data;
    logic [2:0]  rd_rsp_addr;
    logic        rd_rsp_err;

    reg_bank_w16_rd dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_ready (rd_rsp_ready),
        .rd_rsp_data  (rd_rsp_data),
        .rd_rsp_addr  (rd_rsp_addr),
        .rd_rsp_err   (rd_rsp_err)
    );

    always #5 clk = ~clk;

    // Reference: plain array of entry values and a queue of pending responses.
    logic [15:0] m_regs [8];
    exp_t        m_q[$];
    exp_t        got[$];
    int          vectors = 0;
    int          errors  = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Effect of the coming clock edge given the inputs currently applied.
    task automatic model_edge();
        exp_t r;
        bit   fire;
        bit   pop;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
            m_q.delete();
        end else begin
            fire = rd_req_valid && (m_q.size() < 2);
            pop  = (m_q.size() > 0) && rd_rsp_ready;
            r.a = rd_req_addr;
            if (rd_req_addr >= 3'd6) begin
                r.d = 16'hDEAD;
                r.e = 1'b1;
            end else begin
                r.e = 1'b0;
                r.d = (wr_en && wr_addr == rd_req_addr) ? wr_data : m_regs[rd_req_addr];
            end
            if (pop)  void'(m_q.pop_front());
            if (fire) m_q.push_back(r);
            if (wr_en && wr_addr < 3'd6) m_regs[wr_addr] = wr_data;
        end
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    task automatic check_outputs();
        cmp("rsp_valid", 32'(rd_rsp_valid), 32'(m_q.size() != 0));
        cmp("req_ready", 32'(rd_req_ready), 32'(m_q.size() != 2));
        if (m_q.size() != 0) begin
            cmp("rsp_data", 32'(rd_rsp_data), 32'(m_q[0].d));
            cmp("rsp_addr", 32'(rd_rsp_addr), 32'(m_q[0].a));
            cmp("rsp_err",  32'(rd_rsp_err),  32'(m_q[0].e));
        end
    endtask

    // One clock: log any DUT pop, advance the model, then check after the edge.
    task automatic step();
        exp_t g;
        if (!rst && rd_rsp_valid && rd_rsp_ready) begin
            g.d = rd_rsp_data; g.a = rd_rsp_addr; g.e = rd_rsp_err;
            got.push_back(g);
        end
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_req_valid = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        rd_req_valid = 1'b1; rd_req_addr = a; step(); rd_req_valid = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d; step(); wr_en = 1'b0;
    endtask

    task automatic pin_got(input string name, input int idx, input logic [15:0] d,
                           input logic [2:0] a, input logic e);
        if (idx >= got.size()) begin
            cmp({name, "_present"}, 32'(got.size()), 32'(idx + 1));
        end else begin
            cmp({name, "_data"}, 32'(got[idx].d), 32'(d));
            cmp({name, "_addr"}, 32'(got[idx].a), 32'(a));
            cmp({name, "_err"},  32'(got[idx].e), 32'(e));
        end
    endtask

    initial begin
        int base;
        int n;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req_valid = 1'b0; rd_req_addr = '0; rd_rsp_ready = 1'b1;
        @(posedge clk); #1;
        step(); step();
        rst = 1'b0;
        cmp("reset_valid", 32'(rd_rsp_valid), 32'd0);
        cmp("reset_ready", 32'(rd_req_ready), 32'd1);
        cmp("reset_data",  32'(rd_rsp_data),  32'h0);
        cmp("reset_err",   32'(rd_rsp_err),   32'd0);

        // Read every entry after reset.
        got.delete();
        for (int i = 0; i < 6; i++) begin
            rd(3'(i));
            cmp("lat1_valid", 32'(rd_rsp_valid), 32'd1);
        end
        idle(); step(); step();
        cmp("after_reset_count", 32'(got.size()), 32'd6);
        for (int i = 0; i < 6; i++) pin_got("zero_rd", i, 16'h0000, 3'(i), 1'b0);

        // Plain writes then reads.
        got.delete();
        wr(3'd2, 16'h0005); wr(3'd3, 16'h000A);
        rd(3'd2); rd(3'd3); idle(); step(); step();
        pin_got("wr_rd2", 0, 16'h0005, 3'd2, 1'b0);
        pin_got("wr_rd3", 1, 16'h000A, 3'd3, 1'b0);

        // Same-edge write and read of one address.
        got.delete();
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h0003;
        rd_req_valid = 1'b1; rd_req_addr = 3'd4;
        step(); idle(); step(); step();
        pin_got("bypass", 0, 16'h0003, 3'd4, 1'b0);

        // Unmapped addresses.
        got.delete();
        wr(3'd7, 16'h1234);
        rd(3'd6); rd(3'd7); idle(); step(); step();
        pin_got("unmap6", 0, 16'hDEAD, 3'd6, 1'b1);
        pin_got("unmap7", 1, 16'hDEAD, 3'd7, 1'b1);

        // Backpressure: third request stalls until the consumer drains.
        got.delete();
        rd_rsp_ready = 1'b0;
        rd(3'd2); rd(3'd3);
        rd_req_valid = 1'b1; rd_req_addr = 3'd4;
        step(); step(); step();
        cmp("full_ready", 32'(rd_req_ready), 32'd0);
        cmp("full_head",  32'(rd_rsp_data),  32'h0005);
        rd_rsp_ready = 1'b1;
        n = 0;
        while (m_q.size() == 2 && n < 10) begin
            step(); n++;
        end
        cmp("stall_bound", 32'(n < 10), 32'd1);
        step();
        idle(); step(); step(); step();
        cmp("bp_count", 32'(got.size()), 32'd3);
        pin_got("bp0", 0, 16'h0005, 3'd2, 1'b0);
        pin_got("bp1", 1, 16'h000A, 3'd3, 1'b0);
        pin_got("bp2", 2, 16'h0003, 3'd4, 1'b0);

        // Reset with two responses buffered.
        rd_rsp_ready = 1'b0;
        rd(3'd2); rd(3'd3);
        cmp("pre_rst_ready", 32'(rd_req_ready), 32'd0);
        rst = 1'b1; step(); rst = 1'b0;
        cmp("rst_mid_valid", 32'(rd_rsp_valid), 32'd0);
        rd_rsp_ready = 1'b1;
        got.delete();
        rd(3'd2); idle(); step(); step();
        cmp("post_rst_count", 32'(got.size()), 32'd1);
        pin_got("post_rst", 0, 16'h0000, 3'd2, 1'b0);

        // Randomized traffic checked every cycle against the model.
        base = got.size();
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 299) == 0);
            wr_en        = $urandom_range(0, 2) == 0;
            wr_addr      = 3'($urandom_range(0, 7));
            wr_data      = 16'($urandom);
            rd_req_valid = $urandom_range(0, 1) == 1;
            rd_req_addr  = ($urandom_range(0, 1) == 1) ? wr_addr : 3'($urandom_range(0, 7));
            rd_rsp_ready = $urandom_range(0, 3) != 0;
            step();
        end
        rst = 1'b0; idle(); rd_rsp_ready = 1'b1;
        step(); step(); step();
        cmp("random_drained", 32'(rd_rsp_valid), 32'd0);
        cmp("random_traffic", 32'(got.size() > base + 100), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_bank_w16_rd.md
Name: reg_bank_w16_rd

Overview:
- Register bank of NUM_REGS 16-bit entries.
- A simple write port stores data from the producer side.
- A valid/ready read-request port returns stored values to a consumer through a 2-entry response buffer, so a stalled consumer never loses read data.
- Sits between the datapath registers (writer side) and a debug/readback master (reader side).

Parameters:
- WIDTH, 16, data width of every entry.
- ADDR_W, 3, address width.
- NUM_REGS, 6, implemented entries (1..2**ADDR_W); addresses >= NUM_REGS are unmapped.
- ERR_DATA, 16'hDEAD, data returned for an unmapped read.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WIDTH  write data.
- rd_req_valid  in  1  read request present.
- rd_req_ready  out  1  request accepted this cycle when high with valid.
- rd_req_addr  in  ADDR_W  read address.
- rd_rsp_valid  out  1  response at buffer head.
- rd_rsp_ready  in  1  consumer takes the response.
- rd_rsp_data  out  WIDTH  read data.
- rd_rsp_addr  out  ADDR_W  address echoed with the response.
- rd_rsp_err  out  1  response is for an unmapped address.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- Reset:
  - All entries = 0.
  - Response buffer emptied (count = 0).
  - rd_rsp_valid = 0; rd_rsp_data/addr/err = 0.
  - rd_req_ready = 1 in the first cycle after reset.
- Writes:
  - wr_en=1 with wr_addr < NUM_REGS: entry updated at the edge.
  - wr_en=1 with wr_addr >= NUM_REGS: ignored, no error signalled.
  - Writes are independent of read backpressure.
- Request accept: fire = rd_req_valid & rd_req_ready.
  - rd_req_ready = (count != 2). Registered count only; no combinational path from rd_rsp_ready.
- Read data capture on fire:
  - Mapped address: the entry value is captured at the fire edge.
  - Same edge, same mapped address as a write: captured value = wr_data (write-first bypass).
  - Unmapped address: data = ERR_DATA, err = 1.
- Latency: request fired at edge N. The response is visible (rd_rsp_valid=1) in the cycle after edge N, when the buffer was empty or the consumer drained it.
- Response buffer: 2-entry FIFO, head drives the rd_rsp_* outputs.
  - pop = rd_rsp_valid & rd_rsp_ready.
  - Push and pop in the same cycle: count unchanged; order preserved; the head advances to the next entry.
  - Full (count=2): rd_req_ready=0; requests stall with no loss or duplication.
  - Empty: rd_rsp_valid=0; rd_rsp_data holds its last value (don't-care to the consumer).
  - Head outputs stay stable while rd_rsp_valid=1 and rd_rsp_ready=0.
- Reset mid-operation: buffered responses are discarded and the bank is cleared in the same edge. No response from before reset appears afterwards.
- Ordering: responses return strictly in request order.

Decomposition:
- Shared package holds:
  - the WIDTH/ADDR_W defaults;
  - the ERR_DATA constant;
  - a response struct typedef {data, addr, err}.
- Sub-module rsp_fifo2: a 2-entry synchronous FIFO for that struct, with push/pop/count, full/empty, and sync active-high rst.
- The top level holds the register array, write logic, bypass and error mapping.

Test Plan:
- Reset then read addr 0..5, rd_rsp_ready=1 -> six responses, data 16'h0000, err=0, in address order, 1-cycle latency.
- Write addr2=16'h0005, addr3=16'h000A; read 2 then 3 -> 16'h0005 then 16'h000A, rd_rsp_addr echoes 2, 3.
- Same-cycle write addr4=16'h0003 and read addr4 -> response data 16'h0003 (bypass).
- Read addr 6 and addr 7 -> data 16'hDEAD, err=1; prior write of 16'h1234 to addr 7 has no effect.
- Hold rd_rsp_ready=0 and issue 3 requests (addrs 2, 3, 4) -> rd_req_ready drops after 2 accepts; head stays 16'h0005. Then release -> 16'h0005, 16'h000A, 16'h0003 in order, third request accepted.
- With 2 responses buffered, assert rst for 1 cycle -> rd_rsp_valid=0 next cycle; a subsequent read of addr2 returns 16'h0000.
